mmio_timer: RTL and testbench
=============================

Name: mmio_timer

Overview:
- Memory-mapped countdown timer that sits directly downstream of the CPU's data-memory port (m_data_addr / m_data_wdata / m_data_byteen).
- The system address decoder routes matching addresses here instead of to DM.
- Provides three word registers: CTRL, PRESET, COUNT.
- Raises an interrupt request to the CPU when COUNT expires.

Parameters:
- BASE_ADDR, 32'h0000_7F00, word-aligned base address. Bits [31:4] select the block.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  30  word address, CPU m_data_addr[31:2].
- wdata  input  32  store data, CPU m_data_wdata.
- byteen  input  4  per-byte write enable, CPU m_data_byteen.
- rdata  output  32  read data for the addressed register (combinational).
- hit  output  1  addr[31:4] == BASE_ADDR[31:4] (combinational).
- irq  output  1  interrupt request to CPU.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Register map by addr[3:2]:
  - 00 CTRL
  - 01 PRESET
  - 10 COUNT (read-only)
  - 11 reads 0, writes ignored.
- CTRL fields:
  - [0] EN.
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 10/11 behave as 00.
  - [3] IM, interrupt mask (1 = irq allowed).
  - All other bits read 0.
- Write rules:
  - A write occurs when hit & (byteen != 0).
  - Each byte lane i is updated only when byteen[i] = 1; untouched lanes keep their old value.
  - The write commits at the clock edge.
- Reset: CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, irq_flag = 0. irq = 0 and rdata reflects zeroed registers.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if CTRL.EN = 1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN = 0, go to IDLE and COUNT holds.
    - Else if COUNT > 1, COUNT <= COUNT - 1.
    - Else (COUNT is 1 or 0), COUNT <= 0 and go to INT.
  - INT, one-shot: irq_flag <= 1, CTRL.EN <= 0, go to IDLE.
  - INT, auto-reload: irq_flag high for this cycle only, go to LOAD.
- Timing: with PRESET = N ≥ 1, INT is entered N+1 cycles after LOAD. PRESET = 0 behaves as PRESET = 1.
- irq output:
  - irq = CTRL.IM & irq_flag.
  - One-shot: irq_flag is sticky and clears at the edge of any CTRL write.
  - Auto-reload: irq_flag is asserted only while state = INT; the CTRL-write clear does not apply.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle the FSM clears EN (INT, one-shot): the CPU write wins for the written lanes.
  - A PRESET write during CNT does not affect COUNT until the next LOAD.
  - A COUNT write is ignored.
  - EN cleared during LOAD: LOAD still completes, then CNT sees EN = 0 and goes to IDLE.
- Counter arithmetic: unsigned 32-bit, no wrap. Decrement never occurs below 0.
- Reset asserted mid-count: all state returns immediately (asynchronously) to reset values.
- rdata: combinational from addr[3:2] and current register values, valid regardless of hit.

Optional Feature:
- Macro: MMIO_TIMER_PRESCALE_EN.
- Defined:
  - CTRL[15:8] is a read/write prescale field PS.
  - An internal 8-bit prescale counter gates decrements: COUNT decrements only once every PS+1 cycles while in CNT.
  - The prescale counter is cleared in LOAD and IDLE.
  - PS = 0 gives identical timing to the undefined build.
- Undefined: CTRL[15:8] reads 0, writes are ignored, and COUNT decrements every CNT cycle.

Test Plan:
- Reset check: hold reset, then release -> irq = 0; CTRL, PRESET and COUNT read 0.
- One-shot:
  - Stimulus: write PRESET = 5, then CTRL = 32'h9 (EN, IM, one-shot).
  - Response: COUNT reads 5,4,3,2,1,0 on successive cycles. irq rises in the cycle after INT and stays high. CTRL reads 32'h8.
  - Then write CTRL = 0 -> irq = 0 next cycle.
- Auto-reload:
  - Stimulus: PRESET = 3, CTRL = 32'hB.
  - Response: irq is a one-cycle pulse every 5 cycles. COUNT reloads to 3 after each pulse.
- Byte-enable write:
  - Stimulus: PRESET = 32'h1122_3344, then write wdata = 32'hAABB_CCDD with byteen = 4'b0101.
  - Response: PRESET reads 32'h11BB_33DD.
- Masking and stop:
  - Stimulus: CTRL = 32'h1 (IM = 0) with PRESET = 2.
  - Response: irq stays 0 through expiry. Clearing EN mid-count freezes COUNT at its current value.
- Miss and read-only checks:
  - Stimulus: a write with addr outside BASE_ADDR; a write to COUNT.
  - Response: hit = 0 for the outside address and no register changes; COUNT is unchanged by the COUNT write.

Source files
------------

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer with CTRL / PRESET / COUNT
// registers and an interrupt request to the CPU.
// Optional build macro: MMIO_TIMER_PRESCALE_EN adds an 8-bit prescale
// field PS in CTRL[15:8] that slows COUNT decrements to once per PS+1 cycles.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  // Register offsets, taken from word-address bits [1:0] (byte address [3:2])
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_lo_q, ctrl_lo_d;   // {IM, MODE[1:0], EN}
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        sticky_q, sticky_d;     // one-shot expiry flag
`ifdef MMIO_TIMER_PRESCALE_EN
  logic [7:0]  ps_q, ps_d;
  logic [7:0]  ps_cnt_q, ps_cnt_d;
`endif

  logic        wr_en;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        en;
  logic        auto_rl;
  logic        im;
  logic        tick;
  logic [31:0] ctrl_rd;

  // Address decode: word address bits [29:2] correspond to byte address [31:4]
  always_comb begin
    hit       = (addr[29:2] == BASE_ADDR[31:4]);
    wr_en     = hit & (byteen != 4'b0000);
    ctrl_wr   = wr_en & (addr[1:0] == REG_CTRL);
    preset_wr = wr_en & (addr[1:0] == REG_PRESET);
  end

  // CTRL field decode; MODE 10/11 fall back to one-shot
  always_comb begin
    en      = ctrl_lo_q[0];
    auto_rl = (ctrl_lo_q[2:1] == 2'b01);
    im      = ctrl_lo_q[3];
  end

  // Readback view of CTRL with unimplemented bits forced to zero
  always_comb begin
`ifdef MMIO_TIMER_PRESCALE_EN
    ctrl_rd = {16'h0000, ps_q, 4'h0, ctrl_lo_q};
`else
    ctrl_rd = {28'h0000000, ctrl_lo_q};
`endif
  end

  // Combinational read mux, independent of hit
  always_comb begin
    rdata = '0;
    case (addr[1:0])
      REG_CTRL:   rdata = ctrl_rd;
      REG_PRESET: rdata = preset_q;
      REG_COUNT:  rdata = count_q;
      default:    rdata = '0;
    endcase
  end

  // Interrupt: sticky flag in one-shot, live INT state in auto-reload
  always_comb begin
    irq = im & (sticky_q | ((state_q == S_INT) & auto_rl));
  end

  // PRESET byte-lane write merge
  always_comb begin
    preset_d = preset_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (preset_wr && byteen[i]) begin
        preset_d[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Decrement gate: every CNT cycle, or once per PS+1 cycles with prescale
  always_comb begin
    tick = 1'b1;
`ifdef MMIO_TIMER_PRESCALE_EN
    ps_cnt_d = '0;
    if (state_q == S_CNT && en) begin
      if (ps_cnt_q == ps_q) begin
        tick     = 1'b1;
        ps_cnt_d = '0;
      end else begin
        tick     = 1'b0;
        ps_cnt_d = ps_cnt_q + 8'd1;
      end
    end
`endif
  end

  // Next-state, COUNT, CTRL and flag update
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ctrl_lo_d = ctrl_lo_q;
    sticky_d  = sticky_q;
`ifdef MMIO_TIMER_PRESCALE_EN
    ps_d      = ps_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d = '0;
            state_d = S_INT;
          end
        end
      end
      S_INT: begin
        if (auto_rl) begin
          state_d = S_LOAD;
        end else begin
          ctrl_lo_d[0] = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // CPU lanes are applied after the FSM so a same-cycle store wins over
    // the automatic EN clear; the flag is cleared first so that an expiry in
    // the same cycle as a CTRL store is not lost.
    if (ctrl_wr) begin
      sticky_d = 1'b0;
      if (byteen[0]) begin
        ctrl_lo_d = wdata[3:0];
      end
`ifdef MMIO_TIMER_PRESCALE_EN
      if (byteen[1]) begin
        ps_d = wdata[15:8];
      end
`endif
    end

    if (state_q == S_INT && !auto_rl) begin
      sticky_d = 1'b1;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_lo_q <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      sticky_q  <= 1'b0;
`ifdef MMIO_TIMER_PRESCALE_EN
      ps_q      <= '0;
      ps_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_lo_q <= ctrl_lo_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      sticky_q  <= sticky_d;
`ifdef MMIO_TIMER_PRESCALE_EN
      ps_q      <= ps_d;
      ps_cnt_q  <= ps_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: register-access vector table,
// hand-written timing sequences, and randomized register traffic against a
// byte-lane reference model.
module tb_mmio_timer;

  localparam logic [31:0] BASE   = 32'h0000_7F00;
  localparam logic [29:0] BASE_W = BASE[31:2];
`ifdef MMIO_TIMER_PRESCALE_EN
  localparam logic [31:0] CTRL_MASK = 32'h0000_FF0F;
`else
  localparam logic [31:0] CTRL_MASK = 32'h0000_000F;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .byteen(byteen),
    .rdata (rdata),
    .hit   (hit),
    .irq   (irq)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [1:0]  idx;
    logic        miss;
    logic [31:0] d;
    logic [3:0]  be;
    logic [1:0]  ridx;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] be);
    addr   = BASE_W + 30'(idx);
    wdata  = d;
    byteen = be;
    step();
    byteen = '0;
  endtask

  task automatic rd(input logic [1:0] idx, output logic [31:0] v);
    addr = BASE_W + 30'(idx);
    #1;
    v = rdata;
  endtask

  // One-shot run: CTRL write at edge e0, LOAD after e1, COUNT = n after e2,
  // expiry (INT) after e(n'+2) with n' = max(n,1), irq visible from e(n'+3).
  task automatic oneshot(input int unsigned n);
    int unsigned ne;
    logic [31:0] v;
    ne = (n == 0) ? 1 : n;
    wr(2'd1, 32'(n), 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    for (int unsigned j = 1; j <= ne + 6; j++) begin
      step();
      if (j >= 2) begin
        rd(2'd2, v);
        chk("oneshot_count", v, (j - 2 < n) ? 32'(n - (j - 2)) : 32'd0);
      end
      chk("oneshot_irq", 32'(irq), 32'(j >= ne + 3));
    end
    rd(2'd0, v);
    chk("oneshot_ctrl_after", v, 32'h8);
    wr(2'd0, 32'h0, 4'hF);
    chk("oneshot_irq_clear", 32'(irq), 32'd0);
    step();
    chk("oneshot_irq_stay_clear", 32'(irq), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] preset_m;
    logic [31:0] ctrl_m;
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [1:0]  idx;
    logic        miss;

    tbl[0] = '{2'd1, 1'b0, 32'h1122_3344, 4'hF,    2'd1, 32'h1122_3344};
    tbl[1] = '{2'd1, 1'b0, 32'hAABB_CCDD, 4'b0101, 2'd1, 32'h11BB_33DD};
    tbl[2] = '{2'd1, 1'b1, 32'h0000_0000, 4'hF,    2'd1, 32'h11BB_33DD};
    tbl[3] = '{2'd2, 1'b0, 32'hFFFF_FFFF, 4'hF,    2'd2, 32'h0000_0000};
    tbl[4] = '{2'd3, 1'b0, 32'hFFFF_FFFF, 4'hF,    2'd3, 32'h0000_0000};
    tbl[5] = '{2'd0, 1'b0, 32'h0000_000E, 4'b1110, 2'd0, 32'h0000_0000};
    tbl[6] = '{2'd0, 1'b0, 32'h0000_000E, 4'b0001, 2'd0, 32'h0000_000E};
    tbl[7] = '{2'd0, 1'b0, 32'h0000_0000, 4'hF,    2'd0, 32'h0000_0000};
    tbl[8] = '{2'd1, 1'b0, 32'h5500_0000, 4'b1000, 2'd1, 32'h55BB_33DD};
    tbl[9] = '{2'd0, 1'b1, 32'hFFFF_FFFF, 4'hF,    2'd0, 32'h0000_0000};

    // Reset state
    reset  = 1'b1;
    addr   = BASE_W;
    wdata  = '0;
    byteen = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_irq", 32'(irq), 32'd0);
    rd(2'd0, v); chk("reset_ctrl", v, 32'd0);
    rd(2'd1, v); chk("reset_preset", v, 32'd0);
    rd(2'd2, v); chk("reset_count", v, 32'd0);

    // Register access vectors
    for (int i = 0; i < 10; i++) begin
      addr   = tbl[i].miss ? ((BASE_W + 30'(tbl[i].idx)) ^ 30'h100) : (BASE_W + 30'(tbl[i].idx));
      wdata  = tbl[i].d;
      byteen = tbl[i].be;
      #1;
      chk("vec_hit", 32'(hit), 32'(!tbl[i].miss));
      step();
      byteen = '0;
      rd(tbl[i].ridx, v);
      chk("vec_rdata", v, tbl[i].exp);
    end

    // One-shot timing, including PRESET = 0 and 1 boundaries
    oneshot(5);
    oneshot(0);
    oneshot(1);
    for (int k = 0; k < 4; k++) begin
      oneshot($urandom_range(2, 12));
    end

    // Auto-reload: PRESET = 3 gives a 5-cycle period, INT first after e5
    wr(2'd1, 32'd3, 4'hF);
    wr(2'd0, 32'hB, 4'hF);
    for (int j = 1; j <= 21; j++) begin
      step();
      if (j >= 2) begin
        rd(2'd2, v);
        chk("auto_count", v, (((j - 2) % 5) <= 2) ? 32'(3 - ((j - 2) % 5)) : 32'd0);
      end
      chk("auto_irq", 32'(irq), 32'((j >= 5) && (((j - 5) % 5) == 0)));
    end
    wr(2'd0, 32'h0, 4'hF);
    repeat (4) step();
    chk("auto_stop_irq", 32'(irq), 32'd0);

    // Masked expiry: IM = 0 keeps irq low; EN still self-clears
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("mask_irq", 32'(irq), 32'd0);
    end
    rd(2'd0, v); chk("mask_ctrl", v, 32'd0);
    rd(2'd2, v); chk("mask_count", v, 32'd0);

    // Stop mid-count: COUNT freezes at the value after the clearing edge
    wr(2'd1, 32'd10, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    repeat (5) step();
    rd(2'd2, v); chk("stop_count_run", v, 32'd7);
    wr(2'd0, 32'h0, 4'hF);
    for (int j = 0; j < 4; j++) begin
      rd(2'd2, v); chk("stop_count_frozen", v, 32'd6);
      step();
    end

    // Asynchronous reset in the middle of a count
    wr(2'd1, 32'd10, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    repeat (4) step();
    #3;
    reset = 1'b1;
    #1;
    chk("areset_irq", 32'(irq), 32'd0);
    rd(2'd2, v); chk("areset_count", v, 32'd0);
    rd(2'd0, v); chk("areset_ctrl", v, 32'd0);
    step();
    reset = 1'b0;
    rd(2'd1, v); chk("areset_preset", v, 32'd0);
    step();
    rd(2'd2, v); chk("areset_count_idle", v, 32'd0);

    // Randomized register traffic (EN kept low) against a byte-lane model
    preset_m = '0;
    ctrl_m   = '0;
    for (int k = 0; k < 60; k++) begin
      idx  = 2'($urandom_range(0, 3));
      miss = ($urandom_range(0, 3) == 0);
      d    = $urandom;
      if (idx == 2'd0) d[0] = 1'b0;
      be   = 4'($urandom_range(0, 15));
      a    = BASE_W + 30'(idx);
      if (miss) a = a ^ (30'd1 << $urandom_range(2, 29));
      addr   = a;
      wdata  = d;
      byteen = be;
      #1;
      chk("rand_hit", 32'(hit), 32'(!miss));
      step();
      byteen = '0;
      if (!miss) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i] && idx == 2'd1) preset_m[8*i +: 8] = d[8*i +: 8];
          if (be[i] && idx == 2'd0) ctrl_m[8*i +: 8]   = d[8*i +: 8];
        end
        ctrl_m = ctrl_m & CTRL_MASK;
      end
      rd(2'd0, v); chk("rand_ctrl", v, ctrl_m);
      rd(2'd1, v); chk("rand_preset", v, preset_m);
      rd(2'd2, v); chk("rand_count", v, 32'd0);
      chk("rand_irq", 32'(irq), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
